rsa_cmd_ctrl: RTL and testbench
===============================

// Module: rsa_cmd_ctrl
// PURPOSE
//  Command sequencer inside rsa_wrapper between the ARM cmd/data handshakes and the Montgomery/exponentiation core.
//  Decodes 32-bit commands, steers 1024-bit operand loads into the operand registers and starts/soft-resets the core.
//  Streams the result out and raises done until the host acknowledges it.
//  Pure control: the 1024-bit registers and result mux sit outside and are driven by this block's enables.
// PARAMETERS
//  TIMEOUT_CYCLES  32'd2000000  max core cycles before compute is aborted; 0 = no timeout
//  CNT_W           32           width of cycle counter and perf_cycles
// PORTS
//  clk                     in   1      system clock, rising edge
//  resetn                  in   1      asynchronous, active-low reset
//  arm_to_fpga_cmd         in   32     command code (0x0..0xb)
//  arm_to_fpga_cmd_valid   in   1      1-cycle command strobe
//  fpga_to_arm_done        out  1      command finished; held until done_read
//  fpga_to_arm_done_read   in   1      host ack of done
//  arm_to_fpga_data_valid  in   1      host operand valid
//  arm_to_fpga_data_ready  out  1      controller accepts operand
//  fpga_to_arm_data_valid  out  1      result valid
//  fpga_to_arm_data_ready  in   1      host ready for result
//  reg_load_en             out  8      one-hot 1-cycle load strobe: [0]A [1]B [2]M [3]EMOD [4]ERMOD [5]ERSQ [6]EX [7]EEXP
//  core_start              out  1      1-cycle start pulse
//  core_mode               out  1      0 = montgomery multiply, 1 = exponentiation; stable while core busy
//  core_soft_reset         out  1      1-cycle core reset pulse
//  core_done               in   1      core finished (pulse or level)
//  perf_cycles             out  CNT_W  cycle count of last compute
//  err_flags               out  3      sticky {timeout, overrun, illegal_cmd}
//  leds                    out  4      {done, err_any, compute, idle}
// BEHAVIOUR
//  Reset: state IDLE; all outputs 0 except leds = 4'b0001; perf_cycles = 0; err_flags = 0.
//  States: IDLE, RX, COMPUTE, TX, DONE (encoding in defs header). All outputs are registered.
//  IDLE + cmd_valid; next state is entered on the following edge:
//   - cmd 0,1,2,5,6,7,8,9 -> RX; target index latched (0..2 -> 0..2, 5..9 -> 3..7).
//   - cmd 3 / 4 -> COMPUTE; core_mode = 1 / 0; core_start high the first COMPUTE cycle; counter cleared.
//   - cmd 0xA -> TX.
//   - cmd 0xB -> core_soft_reset pulse, err_flags cleared, then DONE.
//   - any other value -> err_flags[0] set, then DONE; done is still raised.
//  RX:
//   - data_ready = 1 throughout.
//   - On an edge with data_valid & data_ready: reg_load_en[idx] = 1 for exactly the next cycle, ready drops, state -> DONE.
//  COMPUTE:
//   - Counter increments each cycle. core_done is ignored in the core_start cycle.
//   - core_done -> perf_cycles = count, state -> DONE.
//   - TIMEOUT_CYCLES != 0 and count reaches it -> err_flags[2] set, core_soft_reset pulse, state -> DONE.
//  TX:
//   - data_valid = 1 until an edge with data_valid & data_ready, then valid drops and state -> DONE.
//  DONE:
//   - done = 1; done_read -> done = 0, state -> IDLE on the next edge.
//  cmd_valid outside IDLE: command dropped and err_flags[1] set, including when cmd_valid coincides with done_read.
//  Host latency: cmd accept to RX ready, or to core_start, is 1 cycle. Transfer edge to done is 1 cycle.
//  Reset mid-operation: immediate return to IDLE and all strobes cleared. Operands outside are not cleared.
//  A data_valid that arrives before RX is held by the host (level handshake) and is accepted once RX is entered.
// STRUCTURE
//  rsa_ctrl_defs.vh holds CMD_* codes 0x0..0xB, state encodings, REG_IDX_* and the LED bit map.
//  Shared with rsa_wrapper and the bench.
//  One sub-module, rsa_cycle_counter: clear, enable, count, terminal-count compare against TIMEOUT_CYCLES.
//  The FSM and the decode stay in rsa_cmd_ctrl.
// TESTING
//  1. cmd 0x1, then data valid -> reg_load_en = 8'h02 for one cycle, then done; done_read -> IDLE, leds = 4'b0001.
//  2. cmd 0x8 and 0x9 -> load strobes 8'h40 and 8'h80. cmd 0x4 -> core_mode = 0, core_start 1 cycle after accept.
//     Model core_done after 37 cycles -> perf_cycles = 37, done = 1.
//  3. cmd 0xA with host ready delayed 5 cycles -> data_valid held 5 cycles, drops on the transfer edge, done follows.
//  4. cmd 0x3 with TIMEOUT_CYCLES = 16 and no core_done -> err_flags = 3'b100, core_soft_reset pulse, done.
//     Then cmd 0xB -> err_flags = 0.
//  5. cmd 0x1F -> err_flags[0] = 1, done. cmd_valid during COMPUTE -> err_flags[1] = 1, running compute unaffected.
//  6. resetn low mid-RX, mid-COMPUTE and mid-TX -> all outputs at reset values. Next full load/compute/write sequence passes.

Source files
------------

// File: rtl/rsa_cmd_ctrl_pkg.sv
// Shared definitions for the RSA command sequencer: command codes, FSM
// encoding, operand register indices, error and LED bit positions.
package rsa_cmd_ctrl_pkg;

    // Host command codes
    localparam logic [31:0] CMD_LOAD_A     = 32'h0;
    localparam logic [31:0] CMD_LOAD_B     = 32'h1;
    localparam logic [31:0] CMD_LOAD_M     = 32'h2;
    localparam logic [31:0] CMD_EXP        = 32'h3;
    localparam logic [31:0] CMD_MONT       = 32'h4;
    localparam logic [31:0] CMD_LOAD_EMOD  = 32'h5;
    localparam logic [31:0] CMD_LOAD_ERMOD = 32'h6;
    localparam logic [31:0] CMD_LOAD_ERSQ  = 32'h7;
    localparam logic [31:0] CMD_LOAD_EX    = 32'h8;
    localparam logic [31:0] CMD_LOAD_EEXP  = 32'h9;
    localparam logic [31:0] CMD_READ       = 32'hA;
    localparam logic [31:0] CMD_SOFT_RESET = 32'hB;

    // Controller states
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RX      = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_TX      = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    // Bit positions inside reg_load_en
    localparam logic [2:0] REG_IDX_A     = 3'd0;
    localparam logic [2:0] REG_IDX_B     = 3'd1;
    localparam logic [2:0] REG_IDX_M     = 3'd2;
    localparam logic [2:0] REG_IDX_EMOD  = 3'd3;
    localparam logic [2:0] REG_IDX_ERMOD = 3'd4;
    localparam logic [2:0] REG_IDX_ERSQ  = 3'd5;
    localparam logic [2:0] REG_IDX_EX    = 3'd6;
    localparam logic [2:0] REG_IDX_EEXP  = 3'd7;

    // Sticky error bits
    localparam int ERR_ILLEGAL = 0;
    localparam int ERR_OVERRUN = 1;
    localparam int ERR_TIMEOUT = 2;

    // LED bit map
    localparam int LED_IDLE    = 0;
    localparam int LED_COMPUTE = 1;
    localparam int LED_ERR     = 2;
    localparam int LED_DONE    = 3;

    // Maps a load command onto the operand register it targets
    function automatic logic [2:0] cmd_to_idx(input logic [31:0] cmd);
        case (cmd)
            CMD_LOAD_B:     return REG_IDX_B;
            CMD_LOAD_M:     return REG_IDX_M;
            CMD_LOAD_EMOD:  return REG_IDX_EMOD;
            CMD_LOAD_ERMOD: return REG_IDX_ERMOD;
            CMD_LOAD_ERSQ:  return REG_IDX_ERSQ;
            CMD_LOAD_EX:    return REG_IDX_EX;
            CMD_LOAD_EEXP:  return REG_IDX_EEXP;
            default:        return REG_IDX_A;
        endcase
    endfunction

endpackage

// File: rtl/rsa_cycle_counter.sv
// Compute-cycle counter. o_elapsed counts the current cycle as well, so in
// the first enabled cycle after a clear it reads 1. o_tc flags the cycle in
// which the elapsed count reaches TIMEOUT_CYCLES (never, when it is 0).
module rsa_cycle_counter #(
    parameter int unsigned CNT_W          = 32,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000000
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             i_clear,
    input  logic             i_en,
    output logic [CNT_W-1:0] o_elapsed,
    output logic             o_tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_count;

    // Count register: clear wins over enable
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_en) begin
            // NOTE: sequential state uses <= so every flop samples pre-edge values; = here would create order-dependent races.
            r_count <= r_count + CNT_W'(1);
        end
    end

    assign o_elapsed = r_count + CNT_W'(1);
    assign o_tc      = i_en && (TIMEOUT_CYCLES != 32'd0) && (o_elapsed == TC_VAL);

endmodule

// File: rtl/rsa_cmd_ctrl.sv
// Command sequencer between the ARM cmd/data handshakes and the RSA core.
// Pure control: operand registers and the result mux live outside and are
// steered by reg_load_en / fpga_to_arm_data_valid. Every output is a flop.
module rsa_cmd_ctrl
    import rsa_cmd_ctrl_pkg::*;
#(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd2000000,
    parameter int unsigned CNT_W          = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [31:0]      arm_to_fpga_cmd,
    input  logic             arm_to_fpga_cmd_valid,
    output logic             fpga_to_arm_done,
    input  logic             fpga_to_arm_done_read,
    input  logic             arm_to_fpga_data_valid,
    output logic             arm_to_fpga_data_ready,
    output logic             fpga_to_arm_data_valid,
    input  logic             fpga_to_arm_data_ready,
    output logic [7:0]       reg_load_en,
    output logic             core_start,
    output logic             core_mode,
    output logic             core_soft_reset,
    input  logic             core_done,
    output logic [CNT_W-1:0] perf_cycles,
    output logic [2:0]       err_flags,
    output logic [3:0]       leds
);

    state_t           r_state;
    logic [2:0]       r_idx;
    logic             r_done;
    logic             r_rx_ready;
    logic             r_tx_valid;
    logic [7:0]       r_load_en;
    logic             r_core_start;
    logic             r_core_mode;
    logic             r_soft_reset;
    logic [CNT_W-1:0] r_perf;
    logic [2:0]       r_err;
    logic [3:0]       r_leds;

    state_t           w_state_nxt;
    logic [2:0]       w_idx_nxt;
    logic             w_done_nxt;
    logic             w_rx_ready_nxt;
    logic             w_tx_valid_nxt;
    logic [7:0]       w_load_en_nxt;
    logic             w_core_start_nxt;
    logic             w_core_mode_nxt;
    logic             w_soft_reset_nxt;
    logic [CNT_W-1:0] w_perf_nxt;
    logic [2:0]       w_err_nxt;
    logic [3:0]       w_leds_nxt;
    logic             w_cnt_clear;
    logic [CNT_W-1:0] w_elapsed;
    logic             w_timeout;

    rsa_cycle_counter #(
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_cycle_counter (
        .clk       (clk),
        .resetn    (resetn),
        .i_clear   (w_cnt_clear),
        .i_en      (r_state == ST_COMPUTE),
        .o_elapsed (w_elapsed),
        .o_tc      (w_timeout)
    );

    // Next-state and next-output decode
    always_comb begin
        // NOTE: every signal gets a default before any branch so no path leaves it unassigned and infers a latch.
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_done_nxt       = r_done;
        w_rx_ready_nxt   = r_rx_ready;
        w_tx_valid_nxt   = r_tx_valid;
        w_load_en_nxt    = '0;
        w_core_start_nxt = 1'b0;
        w_core_mode_nxt  = r_core_mode;
        w_soft_reset_nxt = 1'b0;
        w_perf_nxt       = r_perf;
        w_err_nxt        = r_err;
        w_cnt_clear      = 1'b0;

        // A command is only accepted in IDLE; anything else is an overrun
        if (arm_to_fpga_cmd_valid && (r_state != ST_IDLE)) begin
            w_err_nxt[ERR_OVERRUN] = 1'b1;
        end

        unique case (r_state)
            ST_IDLE: begin
                if (arm_to_fpga_cmd_valid) begin
                    unique case (arm_to_fpga_cmd)
                        CMD_LOAD_A, CMD_LOAD_B, CMD_LOAD_M, CMD_LOAD_EMOD,
                        CMD_LOAD_ERMOD, CMD_LOAD_ERSQ, CMD_LOAD_EX, CMD_LOAD_EEXP: begin
                            w_state_nxt    = ST_RX;
                            w_idx_nxt      = cmd_to_idx(arm_to_fpga_cmd);
                            w_rx_ready_nxt = 1'b1;
                        end
                        CMD_EXP, CMD_MONT: begin
                            w_state_nxt      = ST_COMPUTE;
                            w_core_mode_nxt  = (arm_to_fpga_cmd == CMD_EXP);
                            w_core_start_nxt = 1'b1;
                            w_cnt_clear      = 1'b1;
                        end
                        CMD_READ: begin
                            w_state_nxt    = ST_TX;
                            w_tx_valid_nxt = 1'b1;
                        end
                        CMD_SOFT_RESET: begin
                            w_state_nxt      = ST_DONE;
                            w_done_nxt       = 1'b1;
                            w_soft_reset_nxt = 1'b1;
                            w_err_nxt        = '0;
                        end
                        default: begin
                            w_state_nxt            = ST_DONE;
                            w_done_nxt             = 1'b1;
                            w_err_nxt[ERR_ILLEGAL] = 1'b1;
                        end
                    endcase
                end
            end
            ST_RX: begin
                if (arm_to_fpga_data_valid && r_rx_ready) begin
                    w_load_en_nxt  = 8'b1 << r_idx;
                    w_rx_ready_nxt = 1'b0;
                    w_state_nxt    = ST_DONE;
                    w_done_nxt     = 1'b1;
                end
            end
            ST_COMPUTE: begin
                // core_done is not trusted in the cycle the start pulse is out
                if (core_done && !r_core_start) begin
                    w_perf_nxt  = w_elapsed;
                    w_state_nxt = ST_DONE;
                    w_done_nxt  = 1'b1;
                end else if (w_timeout) begin
                    w_err_nxt[ERR_TIMEOUT] = 1'b1;
                    w_soft_reset_nxt       = 1'b1;
                    w_state_nxt            = ST_DONE;
                    w_done_nxt             = 1'b1;
                end
            end
            ST_TX: begin
                if (r_tx_valid && fpga_to_arm_data_ready) begin
                    w_tx_valid_nxt = 1'b0;
                    w_state_nxt    = ST_DONE;
                    w_done_nxt     = 1'b1;
                end
            end
            ST_DONE: begin
                if (fpga_to_arm_done_read) begin
                    w_done_nxt  = 1'b0;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        w_leds_nxt              = '0;
        w_leds_nxt[LED_IDLE]    = (w_state_nxt == ST_IDLE);
        w_leds_nxt[LED_COMPUTE] = (w_state_nxt == ST_COMPUTE);
        w_leds_nxt[LED_ERR]     = |w_err_nxt;
        w_leds_nxt[LED_DONE]    = w_done_nxt;
    end

    // State and output registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: only control flops are reset here; the wide operand registers outside keep their contents.
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_done       <= 1'b0;
            r_rx_ready   <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_load_en    <= '0;
            r_core_start <= 1'b0;
            r_core_mode  <= 1'b0;
            r_soft_reset <= 1'b0;
            r_perf       <= '0;
            r_err        <= '0;
            r_leds       <= 4'b0001;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_done       <= w_done_nxt;
            r_rx_ready   <= w_rx_ready_nxt;
            r_tx_valid   <= w_tx_valid_nxt;
            r_load_en    <= w_load_en_nxt;
            r_core_start <= w_core_start_nxt;
            r_core_mode  <= w_core_mode_nxt;
            r_soft_reset <= w_soft_reset_nxt;
            r_perf       <= w_perf_nxt;
            r_err        <= w_err_nxt;
            r_leds       <= w_leds_nxt;
        end
    end

    assign fpga_to_arm_done       = r_done;
    assign arm_to_fpga_data_ready = r_rx_ready;
    assign fpga_to_arm_data_valid = r_tx_valid;
    assign reg_load_en            = r_load_en;
    assign core_start             = r_core_start;
    assign core_mode              = r_core_mode;
    assign core_soft_reset        = r_soft_reset;
    assign perf_cycles            = r_perf;
    assign err_flags              = r_err;
    assign leds                   = r_leds;

endmodule

// File: tb/tb_rsa_cmd_ctrl.sv
// Bench for rsa_cmd_ctrl. Stimulus pushes expected output events into a
// queue; a negedge monitor pops and compares whenever the DUT emits one.
// The timeout is set to 40 so a 37-cycle compute still completes.
module tb_rsa_cmd_ctrl;
    import rsa_cmd_ctrl_pkg::*;

    localparam int TB_TIMEOUT = 40;

    typedef enum logic [3:0] {EV_LOAD, EV_START, EV_SRST, EV_TX, EV_DONE} ev_kind_t;
    typedef struct {
        ev_kind_t    kind;
        logic [31:0] val;
    } exp_t;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] cmd;
    logic        cmd_valid;
    logic        done;
    logic        done_read;
    logic        din_valid;
    logic        din_ready;
    logic        dout_valid;
    logic        dout_ready;
    logic [7:0]  load_en;
    logic        core_start;
    logic        core_mode;
    logic        core_soft_reset;
    logic        core_done;
    logic [31:0] perf;
    logic [2:0]  err;
    logic [3:0]  leds;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    int   tx_cnt = 0;
    logic prev_done = 1'b0;

    always #5 clk = ~clk;

    rsa_cmd_ctrl #(
        .TIMEOUT_CYCLES (32'(TB_TIMEOUT)),
        .CNT_W          (32)
    ) dut (
        .clk                    (clk),
        .resetn                 (resetn),
        .arm_to_fpga_cmd        (cmd),
        .arm_to_fpga_cmd_valid  (cmd_valid),
        .fpga_to_arm_done       (done),
        .fpga_to_arm_done_read  (done_read),
        .arm_to_fpga_data_valid (din_valid),
        .arm_to_fpga_data_ready (din_ready),
        .fpga_to_arm_data_valid (dout_valid),
        .fpga_to_arm_data_ready (dout_ready),
        .reg_load_en            (load_en),
        .core_start             (core_start),
        .core_mode              (core_mode),
        .core_soft_reset        (core_soft_reset),
        .core_done              (core_done),
        .perf_cycles            (perf),
        .err_flags              (err),
        .leds                   (leds)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] done_val(input logic [23:0] p, input logic [2:0] e, input logic [3:0] l);
        return {p, 1'b0, e, l};
    endfunction

    task automatic push(input ev_kind_t k, input logic [31:0] v);
        exp_t x;
        x.kind = k;
        x.val  = v;
        sb_q.push_back(x);
    endtask

    task automatic observe(input ev_kind_t k, input logic [31:0] v);
        exp_t x;
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_%s: got %0h expected none", k.name(), v);
        end else begin
            x = sb_q.pop_front();
            check({"ev_", x.kind.name()}, {28'b0, k, v}, {28'b0, x.kind, x.val});
        end
    endtask

    // Monitor: turn DUT outputs into events, in a fixed per-cycle order
    always @(negedge clk) begin
        if (!resetn) begin
            tx_cnt    = 0;
            prev_done = 1'b0;
        end else begin
            if (load_en != 8'h00) observe(EV_LOAD, {24'b0, load_en});
            if (core_start)       observe(EV_START, {31'b0, core_mode});
            if (core_soft_reset)  observe(EV_SRST, 32'h0);
            if (dout_valid) begin
                tx_cnt++;
            end else if (tx_cnt != 0) begin
                observe(EV_TX, 32'(tx_cnt));
                tx_cnt = 0;
            end
            if (done && !prev_done) observe(EV_DONE, done_val(perf[23:0], err, leds));
            prev_done = done;
        end
    end

    task automatic send_cmd(input logic [31:0] c);
        @(posedge clk);
        #1;
        cmd       = c;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic load_operand();
        bit ok = 0;
        din_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (din_ready) begin
                @(posedge clk);
                #1;
                din_valid = 1'b0;
                ok = 1;
                break;
            end
        end
        if (!ok) begin
            din_valid = 1'b0;
            check("rx_ready_wait", 64'(ok), 64'd1);
        end
    endtask

    task automatic wait_done(input string name, input int budget);
        bit seen = 0;
        for (int i = 0; i < budget; i++) begin
            if (done) begin
                seen = 1;
                break;
            end
            @(negedge clk);
        end
        if (!seen) check({name, "_done_wait"}, 64'(seen), 64'd1);
    endtask

    task automatic ack_done(input string name, input logic [3:0] exp_leds);
        done_read = 1'b1;
        @(posedge clk);
        #1;
        done_read = 1'b0;
        check({name, "_idle_leds"}, 64'(leds), 64'(exp_leds));
    endtask

    task automatic wait_drain(input string name);
        for (int i = 0; i < 20 && sb_q.size() != 0; i++) @(negedge clk);
        check({name, "_drained"}, 64'(sb_q.size()), 64'd0);
    endtask

    task automatic check_reset(input string name);
        check({name, "_outs"},
              64'({done, din_ready, dout_valid, load_en, core_start, core_mode, core_soft_reset, err, leds}),
              64'h1);
        check({name, "_perf"}, 64'(perf), 64'd0);
    endtask

    task automatic reset_pulse(input string name);
        #2;
        resetn = 1'b0;
        #1;
        check_reset(name);
        @(posedge clk);
        #1;
        resetn = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        resetn     = 1'b0;
        cmd        = '0;
        cmd_valid  = 1'b0;
        done_read  = 1'b0;
        din_valid  = 1'b0;
        dout_ready = 1'b0;
        core_done  = 1'b0;
        #23;
        check_reset("reset");
        @(posedge clk);
        #1;
        resetn = 1'b1;

        // 1: load B
        push(EV_LOAD, 32'h02);
        push(EV_DONE, done_val(24'd0, 3'b000, 4'b1000));
        send_cmd(CMD_LOAD_B);
        check("rx_ready_latency", 64'(din_ready), 64'd1);
        load_operand();
        wait_done("load_b", 20);
        ack_done("load_b", 4'b0001);
        wait_drain("t1");

        // 2: load EX, EEXP, then montgomery compute of 37 cycles
        push(EV_LOAD, 32'h40);
        push(EV_DONE, done_val(24'd0, 3'b000, 4'b1000));
        send_cmd(CMD_LOAD_EX);
        load_operand();
        wait_done("load_ex", 20);
        ack_done("load_ex", 4'b0001);
        push(EV_LOAD, 32'h80);
        push(EV_DONE, done_val(24'd0, 3'b000, 4'b1000));
        send_cmd(CMD_LOAD_EEXP);
        load_operand();
        wait_done("load_eexp", 20);
        ack_done("load_eexp", 4'b0001);
        push(EV_START, 32'h0);
        push(EV_DONE, done_val(24'd37, 3'b000, 4'b1000));
        send_cmd(CMD_MONT);
        check("start_latency", 64'({core_start, core_mode}), 64'b10);
        check("compute_leds", 64'(leds), 64'b0010);
        repeat (36) @(posedge clk);
        #1;
        core_done = 1'b1;
        @(posedge clk);
        #1;
        core_done = 1'b0;
        wait_done("mont", 20);
        ack_done("mont", 4'b0001);
        wait_drain("t2");

        // 3: read with host ready delayed
        push(EV_TX, 32'd5);
        push(EV_DONE, done_val(24'd37, 3'b000, 4'b1000));
        send_cmd(CMD_READ);
        repeat (4) @(posedge clk);
        #1;
        check("tx_valid_held", 64'(dout_valid), 64'd1);
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
        wait_done("read", 20);
        ack_done("read", 4'b0001);
        wait_drain("t3");

        // 4: exponentiation with no core_done -> timeout, then soft reset
        push(EV_START, 32'h1);
        push(EV_SRST, 32'h0);
        push(EV_DONE, done_val(24'd37, 3'b100, 4'b1100));
        send_cmd(CMD_EXP);
        n = 1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("timeout_cycle", 64'(n), 64'(TB_TIMEOUT + 1));
        ack_done("timeout", 4'b0101);
        push(EV_SRST, 32'h0);
        push(EV_DONE, done_val(24'd37, 3'b000, 4'b1000));
        send_cmd(CMD_SOFT_RESET);
        wait_done("soft_reset", 20);
        ack_done("soft_reset", 4'b0001);
        wait_drain("t4");

        // 5: illegal command, then overrun during compute
        push(EV_DONE, done_val(24'd37, 3'b001, 4'b1100));
        send_cmd(32'h1F);
        wait_done("illegal", 20);
        ack_done("illegal", 4'b0101);
        push(EV_START, 32'h0);
        push(EV_DONE, done_val(24'd20, 3'b011, 4'b1100));
        send_cmd(CMD_MONT);
        repeat (4) @(posedge clk);
        #1;
        cmd       = CMD_LOAD_A;
        cmd_valid = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        check("overrun_state", 64'({err, core_mode, din_ready, leds}), 64'({3'b011, 1'b0, 1'b0, 4'b0110}));
        repeat (14) @(posedge clk);
        #1;
        core_done = 1'b1;
        @(posedge clk);
        #1;
        core_done = 1'b0;
        wait_done("overrun_compute", 20);
        ack_done("overrun_compute", 4'b0101);
        push(EV_SRST, 32'h0);
        push(EV_DONE, done_val(24'd20, 3'b000, 4'b1000));
        send_cmd(CMD_SOFT_RESET);
        wait_done("clear", 20);
        cmd       = CMD_LOAD_A;
        cmd_valid = 1'b1;
        done_read = 1'b1;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        done_read = 1'b0;
        check("cmd_with_done_read", 64'({err, leds, din_ready}), 64'({3'b010, 4'b0101, 1'b0}));
        wait_drain("t5");

        // 6: reset in the middle of RX, COMPUTE and TX
        send_cmd(CMD_LOAD_M);
        repeat (2) @(posedge clk);
        reset_pulse("rst_rx");
        push(EV_START, 32'h1);
        send_cmd(CMD_EXP);
        repeat (3) @(posedge clk);
        reset_pulse("rst_compute");
        send_cmd(CMD_READ);
        repeat (2) @(posedge clk);
        reset_pulse("rst_tx");
        wait_drain("t6_resets");

        // Full sequence after reset; operand valid raised before the command
        push(EV_LOAD, 32'h01);
        push(EV_DONE, done_val(24'd0, 3'b000, 4'b1000));
        din_valid = 1'b1;
        send_cmd(CMD_LOAD_A);
        load_operand();
        wait_done("seq_load", 20);
        ack_done("seq_load", 4'b0001);
        push(EV_START, 32'h0);
        push(EV_DONE, done_val(24'd10, 3'b000, 4'b1000));
        send_cmd(CMD_MONT);
        repeat (9) @(posedge clk);
        #1;
        core_done = 1'b1;
        @(posedge clk);
        #1;
        core_done = 1'b0;
        wait_done("seq_compute", 20);
        ack_done("seq_compute", 4'b0001);
        push(EV_TX, 32'd1);
        push(EV_DONE, done_val(24'd10, 3'b000, 4'b1000));
        send_cmd(CMD_READ);
        dout_ready = 1'b1;
        @(posedge clk);
        #1;
        dout_ready = 1'b0;
        wait_done("seq_read", 20);
        ack_done("seq_read", 4'b0001);
        wait_drain("t6_seq");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
